// File: rtl/dmem_ctrl_if.sv
// Signal bundle between the MEM-stage pipeline, the dmem_ctrl block and the
// external data bus. The master side is the controller; the slave side is the
// pipeline/bus environment that drives requests and acknowledges transfers.
interface dmem_ctrl_if;
  // pipeline request (MEMP)
  logic        req_MEMP;
  logic        we_MEMP;
  logic [63:0] addr_MEMP;
  logic [63:0] wdata_MEMP;
  logic [1:0]  size_MEMP;
  logic        unsigned_MEMP;
  // pipeline response (MEMR) and hazard/status
  logic [63:0] rdata_MEMR;
  logic        rdata_valid_MEMR;
  logic [1:0]  state;
  logic        fault;
  // external data bus
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_ack;
  logic [63:0] bus_rdata;

  modport master (
    input  req_MEMP, we_MEMP, addr_MEMP, wdata_MEMP, size_MEMP, unsigned_MEMP,
    input  bus_ack, bus_rdata,
    output rdata_MEMR, rdata_valid_MEMR, state, fault,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb
  );

  modport slave (
    output req_MEMP, we_MEMP, addr_MEMP, wdata_MEMP, size_MEMP, unsigned_MEMP,
    output bus_ack, bus_rdata,
    input  rdata_MEMR, rdata_valid_MEMR, state, fault,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: takes one load/store from MEMP, runs a
// req/ack transfer on the 64-bit data bus, returns extended load data to MEMR
// and exposes its FSM encoding as the busy/freeze state for the hazard unit.
module dmem_ctrl #(
  parameter int ACK_TIMEOUT = 255   // cycles to wait for bus_ack; 0 = never give up
) (
  input logic         clk,
  input logic         rst,
  dmem_ctrl_if.master dm
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam bit TO_EN = (ACK_TIMEOUT > 0);
  localparam int CW    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  state_t        r_state;
  logic [2:0]    r_off;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [CW-1:0] r_cnt;
  logic          r_bus_req;
  logic          r_bus_we;
  logic [63:0]   r_bus_addr;
  logic [63:0]   r_bus_wdata;
  logic [7:0]    r_bus_wstrb;
  logic [63:0]   r_rdata;
  logic          r_rvalid;
  logic          r_fault;

  logic          w_misal;
  logic [2:0]    w_off;
  logic [7:0]    w_strb_base;
  logic [63:0]   w_lane_wdata;
  logic [7:0]    w_lane_strb;
  logic [63:0]   w_rsh;
  logic [63:0]   w_ld;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_timeout;

  assign w_off        = dm.addr_MEMP[2:0];
  assign w_lane_wdata = dm.wdata_MEMP << {w_off, 3'b000};
  assign w_lane_strb  = w_strb_base << w_off;
  assign w_rsh        = dm.bus_rdata >> {r_off, 3'b000};
  assign w_cnt_nxt    = r_cnt + CW'(1);
  assign w_timeout    = TO_EN && (w_cnt_nxt == CW'(ACK_TIMEOUT));

  // Alignment check and byte-enable pattern for the incoming request.
  always_comb begin
    w_misal     = 1'b0;
    w_strb_base = 8'h01;
    case (dm.size_MEMP)
      2'd0: begin w_misal = 1'b0;               w_strb_base = 8'h01; end
      2'd1: begin w_misal = dm.addr_MEMP[0];    w_strb_base = 8'h03; end
      2'd2: begin w_misal = |dm.addr_MEMP[1:0]; w_strb_base = 8'h0F; end
      default: begin w_misal = |dm.addr_MEMP[2:0]; w_strb_base = 8'hFF; end
    endcase
  end

  // Load data: select the addressed lane and extend to 64 bits.
  always_comb begin
    w_ld = w_rsh;
    case (r_size)
      2'd0: w_ld = r_uns ? {56'b0, w_rsh[7:0]}  : {{56{w_rsh[7]}},  w_rsh[7:0]};
      2'd1: w_ld = r_uns ? {48'b0, w_rsh[15:0]} : {{48{w_rsh[15]}}, w_rsh[15:0]};
      2'd2: w_ld = r_uns ? {32'b0, w_rsh[31:0]} : {{32{w_rsh[31]}}, w_rsh[31:0]};
      default: w_ld = w_rsh;   // doubleword: nothing to extend
    endcase
  end

  // Access FSM; every output, including state, comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_off       <= '0;
      r_size      <= '0;
      r_uns       <= 1'b0;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (dm.req_MEMP) begin
            if (w_misal) begin
              // Misaligned: never touch the bus, just flag it.
              r_fault  <= 1'b1;
              r_rvalid <= 1'b0;
            end else begin
              r_off       <= w_off;
              r_size      <= dm.size_MEMP;
              r_uns       <= dm.unsigned_MEMP;
              r_cnt       <= '0;
              r_bus_req   <= 1'b1;
              r_bus_we    <= dm.we_MEMP;
              r_bus_addr  <= {dm.addr_MEMP[63:3], 3'b000};
              // Loads drive no byte enables and no write data.
              r_bus_wdata <= dm.we_MEMP ? w_lane_wdata : 64'd0;
              r_bus_wstrb <= dm.we_MEMP ? w_lane_strb  : 8'd0;
              r_state     <= dm.we_MEMP ? S_WRITE : S_READ;
            end
          end
        end
        S_READ, S_WRITE: begin
          // Ack wins over a timeout landing on the same edge.
          if (dm.bus_ack) begin
            r_bus_req <= 1'b0;
            r_state   <= S_DONE;
            if (r_state == S_READ) begin
              r_rdata  <= w_ld;
              r_rvalid <= 1'b1;
            end else begin
              r_rvalid <= 1'b0;
            end
          end else if (w_timeout) begin
            r_bus_req <= 1'b0;
            r_fault   <= 1'b1;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: begin
          // DONE: one cycle with bus_req low, then accept again.
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dm.state            = r_state;
  assign dm.bus_req          = r_bus_req;
  assign dm.bus_we           = r_bus_we;
  assign dm.bus_addr         = r_bus_addr;
  assign dm.bus_wdata        = r_bus_wdata;
  assign dm.bus_wstrb        = r_bus_wstrb;
  assign dm.rdata_MEMR       = r_rdata;
  assign dm.rdata_valid_MEMR = r_rvalid;
  assign dm.fault            = r_fault;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: stimulus pushes the expected completion
// (rdata/valid/fault) when a request is issued; a monitor pops and compares
// whenever the DUT shows DONE or a fault pulse. Bus-side timing is checked
// inline while each access runs.
module tb_dmem_ctrl;

  logic clk;
  logic rst;
  dmem_ctrl_if dif();

  dmem_ctrl #(.ACK_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .dm  (dif.master)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        valid;
    logic        fault;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every DONE cycle or fault pulse is one completion event.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (dif.state == 2'b11 || dif.fault === 1'b1)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion state=%b fault=%b t=%0t", dif.state, dif.fault, $time);
      end else begin
        e = q.pop_front();
        chk("mon_rdata", dif.rdata_MEMR, e.rdata);
        chk("mon_valid", {63'd0, dif.rdata_valid_MEMR}, {63'd0, e.valid});
        chk("mon_fault", {63'd0, dif.fault}, {63'd0, e.fault});
      end
    end
  end

  // One aligned access with `waits` no-ack cycles before the ack cycle.
  // Called and returns at posedge+1 with the DUT back in IDLE.
  task automatic access(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [1:0] size, input logic uns, input int waits,
                        input logic [63:0] rd, input logic [63:0] exp_rd,
                        input logic [63:0] exp_ba, input logic [63:0] exp_wd,
                        input logic [7:0] exp_strb, input string nm);
    logic [1:0] st;
    st = we ? 2'b10 : 2'b01;
    q.push_back('{rdata: exp_rd, valid: ~we, fault: 1'b0});
    dif.req_MEMP = 1'b1; dif.we_MEMP = we; dif.addr_MEMP = addr;
    dif.wdata_MEMP = wdata; dif.size_MEMP = size; dif.unsigned_MEMP = uns;
    @(posedge clk); #1;
    dif.req_MEMP = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      dif.bus_ack   = (i == waits);
      dif.bus_rdata = (i == waits) ? rd : 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      chk({nm, "_state"}, {62'd0, dif.state}, {62'd0, st});
      chk({nm, "_bus_req"}, {63'd0, dif.bus_req}, 64'd1);
      chk({nm, "_bus_we"}, {63'd0, dif.bus_we}, {63'd0, we});
      chk({nm, "_bus_addr"}, dif.bus_addr, exp_ba);
      chk({nm, "_bus_wstrb"}, {56'd0, dif.bus_wstrb}, {56'd0, exp_strb});
      if (we) chk({nm, "_bus_wdata"}, dif.bus_wdata, exp_wd);
      @(posedge clk); #1;
    end
    dif.bus_ack = 1'b0;
    @(negedge clk);
    chk({nm, "_done_state"}, {62'd0, dif.state}, 64'd3);
    chk({nm, "_done_req"}, {63'd0, dif.bus_req}, 64'd0);
    @(posedge clk); #1;
    chk({nm, "_idle_state"}, {62'd0, dif.state}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    dif.req_MEMP = 1'b0; dif.we_MEMP = 1'b0; dif.addr_MEMP = '0; dif.wdata_MEMP = '0;
    dif.size_MEMP = '0; dif.unsigned_MEMP = 1'b0; dif.bus_ack = 1'b0; dif.bus_rdata = '0;
    @(negedge clk);
    chk("rst_state", {62'd0, dif.state}, 64'd0);
    chk("rst_bus_req", {63'd0, dif.bus_req}, 64'd0);
    chk("rst_bus_we", {63'd0, dif.bus_we}, 64'd0);
    chk("rst_bus_addr", dif.bus_addr, 64'd0);
    chk("rst_bus_wdata", dif.bus_wdata, 64'd0);
    chk("rst_bus_wstrb", {56'd0, dif.bus_wstrb}, 64'd0);
    chk("rst_rdata", dif.rdata_MEMR, 64'd0);
    chk("rst_valid", {63'd0, dif.rdata_valid_MEMR}, 64'd0);
    chk("rst_fault", {63'd0, dif.fault}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // aligned doubleword load, zero wait
    access(1'b0, 64'h1000, 64'd0, 2'd3, 1'b0, 0, 64'h8877665544332211,
           64'h8877665544332211, 64'h1000, 64'd0, 8'h00, "ld");
    // LB / LBU on byte 3
    access(1'b0, 64'h1003, 64'd0, 2'd0, 1'b0, 0, 64'h00000000F0000000,
           64'hFFFFFFFFFFFFFFF0, 64'h1000, 64'd0, 8'h00, "lb");
    access(1'b0, 64'h1003, 64'd0, 2'd0, 1'b1, 1, 64'h00000000F0000000,
           64'h00000000000000F0, 64'h1000, 64'd0, 8'h00, "lbu");

    // misaligned LW: fault pulse, no bus, valid cleared, rdata kept
    q.push_back('{rdata: 64'h00000000000000F0, valid: 1'b0, fault: 1'b1});
    dif.req_MEMP = 1'b1; dif.we_MEMP = 1'b0; dif.addr_MEMP = 64'h3002;
    dif.size_MEMP = 2'd2; dif.unsigned_MEMP = 1'b0;
    @(posedge clk); #1;
    dif.req_MEMP = 1'b0;
    chk("mis_state", {62'd0, dif.state}, 64'd0);
    chk("mis_bus_req", {63'd0, dif.bus_req}, 64'd0);
    @(posedge clk); #1;
    chk("mis_state2", {62'd0, dif.state}, 64'd0);
    chk("mis_bus_req2", {63'd0, dif.bus_req}, 64'd0);
    chk("mis_fault_clear", {63'd0, dif.fault}, 64'd0);

    // SH with 3 wait states; completion clears valid
    access(1'b1, 64'h2006, 64'h000000000000ABCD, 2'd1, 1'b0, 3, 64'd0,
           64'h00000000000000F0, 64'h2000, 64'hABCD000000000000, 8'hC0, "sh");

    // timeout: ack never comes
    q.push_back('{rdata: 64'd0, valid: 1'b0, fault: 1'b1});
    dif.req_MEMP = 1'b1; dif.we_MEMP = 1'b0; dif.addr_MEMP = 64'h6000;
    dif.size_MEMP = 2'd3; dif.unsigned_MEMP = 1'b0;
    @(posedge clk); #1;
    dif.req_MEMP = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_state", {62'd0, dif.state}, 64'd1);
      chk("to_bus_req", {63'd0, dif.bus_req}, 64'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_done_state", {62'd0, dif.state}, 64'd3);
    @(posedge clk); #1;
    chk("to_idle_state", {62'd0, dif.state}, 64'd0);

    // reset in the second wait cycle of a read
    dif.req_MEMP = 1'b1; dif.we_MEMP = 1'b0; dif.addr_MEMP = 64'h7000; dif.size_MEMP = 2'd3;
    @(posedge clk); #1;
    dif.req_MEMP = 1'b0;
    @(posedge clk); #3;
    chk("rr_pre_req", {63'd0, dif.bus_req}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rr_bus_req", {63'd0, dif.bus_req}, 64'd0);
    chk("rr_state", {62'd0, dif.state}, 64'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // loads after reset; size 3 ignores unsigned
    access(1'b0, 64'h8008, 64'd0, 2'd3, 1'b1, 2, 64'hF123456789ABCDEF,
           64'hF123456789ABCDEF, 64'h8008, 64'd0, 8'h00, "ld2");
    access(1'b0, 64'h4004, 64'd0, 2'd2, 1'b0, 0, 64'h89ABCDEF00000000,
           64'hFFFFFFFF89ABCDEF, 64'h4000, 64'd0, 8'h00, "lw");
    access(1'b0, 64'h4002, 64'd0, 2'd1, 1'b0, 0, 64'h0000000080010000,
           64'hFFFFFFFFFFFF8001, 64'h4000, 64'd0, 8'h00, "lh");
    access(1'b0, 64'h4002, 64'd0, 2'd1, 1'b1, 1, 64'h0000000080010000,
           64'h0000000000008001, 64'h4000, 64'd0, 8'h00, "lhu");
    access(1'b0, 64'h4004, 64'd0, 2'd2, 1'b1, 0, 64'h89ABCDEF00000000,
           64'h0000000089ABCDEF, 64'h4000, 64'd0, 8'h00, "lwu");
    // stores: lane shift and strobes
    access(1'b1, 64'h5005, 64'h0000000000001234, 2'd0, 1'b0, 0, 64'd0,
           64'h0000000089ABCDEF, 64'h5000, 64'h0012340000000000, 8'h20, "sb");
    access(1'b1, 64'h5008, 64'hCAFEF00D12345678, 2'd3, 1'b0, 1, 64'd0,
           64'h0000000089ABCDEF, 64'h5008, 64'hCAFEF00D12345678, 8'hFF, "sd");

    @(posedge clk); #1;
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller for the pipeline's MEM stages. It accepts one load/store request per instruction from MEMP and runs a req/ack handshake on the external data bus. It returns aligned, sign/zero-extended load data to MEMR. It drives the 2-bit `state` that the hazard unit ORs into `mem_busy` to freeze IFP through MEMR while an access is outstanding.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 255: maximum cycles waiting for `bus_ack` before abort; 0 disables the timeout.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_MEMP` in 1: valid load/store request this cycle.
- `we_MEMP` in 1: 1 = store, 0 = load.
- `addr_MEMP` in 64: byte address.
- `wdata_MEMP` in 64: store data, right-justified.
- `size_MEMP` in 2: 0 = byte, 1 = half, 2 = word, 3 = double.
- `unsigned_MEMP` in 1: zero-extend the load (LBU/LHU/LWU).
- `rdata_MEMR` out 64: extended load result.
- `rdata_valid_MEMR` out 1: `rdata_MEMR` holds the result of the most recent completed load.
- `state` out 2: 00 IDLE, 01 READ, 10 WRITE, 11 DONE; nonzero means busy.
- `fault` out 1: one-cycle pulse on a misaligned request or a timeout.
- `bus_req` out 1: bus request.
- `bus_we` out 1: bus write enable.
- `bus_addr` out 64: 8-byte-aligned address, `addr & ~7`.
- `bus_wdata` out 64: store data shifted to its lane.
- `bus_wstrb` out 8: byte enables.
- `bus_ack` in 1: transfer complete. Read data is valid in the same cycle.
- `bus_rdata` in 64: read data.

## Operation
- FSM is IDLE → READ/WRITE → DONE → IDLE. The encoding equals `state`, registered directly.
- IDLE with `req_MEMP`=1 and the address aligned (`addr[size-1:0]`==0 for size>0):
  - latch we, addr, wdata, size, unsigned;
  - next state is READ (we=0) or WRITE (we=1).
- IDLE with `req_MEMP`=1 and the address misaligned:
  - no bus activity; `fault`=1 next cycle; stay IDLE;
  - `rdata_valid_MEMR` is cleared.
- Requests in any non-IDLE state are ignored. The pipeline is frozen by `state`, so none should arrive.
- READ/WRITE:
  - `bus_req`=1; `bus_addr`, `bus_we`, `bus_wdata`, `bus_wstrb` stay stable until `bus_ack` is sampled;
  - on `bus_ack`, go to DONE.
- Write lanes, with off = `addr[2:0]`:
  - `bus_wdata` = `wdata << (8*off)`;
  - `bus_wstrb` = (byte 0x01, half 0x03, word 0x0F, double 0xFF) << off.
- Load (on the ack cycle):
  - shift `bus_rdata` right by 8*off;
  - take 8/16/32/64 bits according to size;
  - sign-extend unless unsigned; size 3 ignores unsigned;
  - register the result into `rdata_MEMR`; set `rdata_valid_MEMR`=1.
- Store completion clears `rdata_valid_MEMR`.
- DONE: `bus_req`=0 for exactly one cycle, then IDLE. Outputs keep their values until the next load completes.
- Timeout, when enabled:
  - a counter resets on entry to READ/WRITE and increments every cycle without ack;
  - when it reaches `ACK_TIMEOUT`: `fault` pulses, go to DONE, `rdata_MEMR`=0, `rdata_valid_MEMR`=0.
- `bus_ack` while in IDLE or DONE is ignored.

## Timing
- Reset values: `state`=00, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `bus_wstrb`=0, `rdata_MEMR`=0, `rdata_valid_MEMR`=0, `fault`=0, timeout counter 0.
- Reset mid-transaction drops `bus_req` immediately (asynchronous) and returns to IDLE. The bus side must tolerate an abandoned request.
- Request sampled at edge E0. With a zero-wait ack in the first cycle after E0:
  - state is 01/10 between E0 and E1;
  - DONE between E1 and E2;
  - IDLE from E2.
- The minimum busy window is 2 cycles. Each extra wait cycle adds 1.
- `rdata_MEMR` is valid from the DONE cycle onward, while the hazard unit still holds MEMR frozen.
- `state` and all bus outputs are registered; there is no combinational path from `req_MEMP` to `bus_*`.
- The `fault` pulse appears in the cycle after the offending request or the timeout edge.
- Back-to-back accesses: the next request can be accepted in the first IDLE cycle after DONE.

## Test plan
- **Aligned LD:** addr 0x1000, size 3, ack 1 cycle after `bus_req`, `bus_rdata`=0x8877665544332211.
  - Required: `bus_addr`=0x1000, `bus_wstrb`=0, state 01,11,00; `rdata_MEMR`=0x8877665544332211, valid=1.
- **LB vs LBU:** addr 0x1003, `bus_rdata`=0x00000000F0000000.
  - LB: `rdata_MEMR`=0xFFFFFFFFFFFFFFF0.
  - LBU: `rdata_MEMR`=0x00000000000000F0.
- **SH with wait states:** addr 0x2006, wdata 0xABCD, ack after 3 wait cycles.
  - Required: `bus_wdata`=0xABCD000000000000, `bus_wstrb`=0xC0, stable across the waits; state 10 for 4 cycles, then 11, then 00.
- **Misaligned LW:** addr 0x3002, size 2.
  - Required: `bus_req` never rises, `fault` pulses once, state stays 00, valid=0.
- **Timeout:** `ACK_TIMEOUT`=4, load with `bus_ack` never asserted.
  - Required: state 01 for 4 cycles, then 11 with `fault`=1, then 00; `rdata_MEMR`=0.
- **Reset mid-read:** assert `rst` in the second wait cycle.
  - Required: `bus_req`=0 and state=00 before the next edge; a subsequent LD completes normally.
